// File: rtl/vga_rx.sv
`timescale 1ns/1ps
// vga_rx: VGA timing receiver.
//   Samples Hs/Vs/RGB once (S1) and keeps the previous sample (S2) for edge
//   detection. Measures line and frame length, tracks timing lock with a
//   three-state FSM and emits a pixel stream with column/row coordinates.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   vgaHs, vgaVs        sync inputs, active low
//   vgaR/vgaG/vgaB      3-bit colour inputs
//   pix_valid           active pixel on pix_* this cycle
//   pix_x, pix_y        column / row of the active pixel (held when not valid)
//   pix_rgb             {R,G,B} of the active pixel (held when not valid)
//   frame_start         one-cycle pulse after every Vs falling edge
//   locked              high while timing has been verified
//   sync_err            one-cycle pulse per timing violation (SEEK/LOCKED only)
//   err_cnt             saturating count of sync_err pulses
module vga_rx #(
   parameter int H_LINE         = 800,
   parameter int H_SYNC_CYC     = 96,
   parameter int H_BACK_PORCH   = 48,
   parameter int H_ACTIVE_VIDEO = 640,
   parameter int V_LINE         = 525,
   parameter int V_SYNC_CYC     = 2,
   parameter int V_BACK_PORCH   = 33,
   parameter int V_ACTIVE_VIDEO = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vgaHs,
   input  logic       vgaVs,
   input  logic [2:0] vgaR,
   input  logic [2:0] vgaG,
   input  logic [2:0] vgaB,
   output logic       pix_valid,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [8:0] pix_rgb,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err,
   output logic [7:0] err_cnt
);

   localparam logic [9:0] H_START = 10'(H_SYNC_CYC + H_BACK_PORCH);
   localparam logic [9:0] H_END   = 10'(H_SYNC_CYC + H_BACK_PORCH + H_ACTIVE_VIDEO);
   localparam logic [9:0] V_START = 10'(V_SYNC_CYC + V_BACK_PORCH);
   localparam logic [9:0] V_END   = 10'(V_SYNC_CYC + V_BACK_PORCH + V_ACTIVE_VIDEO);
   localparam logic [9:0] H_LAST  = 10'(H_LINE - 1);
   localparam logic [9:0] V_LAST  = 10'(V_LINE - 1);
   localparam logic [9:0] CNT_MAX = 10'd1023;
   localparam logic [9:0] CNT_PRE = 10'd1022;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SEEK     = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   state_t     state, state_next;
   logic       seek_bad, seek_bad_next;

   logic       hs_s1, vs_s1, hs_s2, vs_s2;
   logic [8:0] rgb_s1, rgb_s2;
   logic [9:0] hc, vc;

   logic       hfe, vfe;
   logic       line_viol, frame_viol, h_timeout, v_timeout, viol;
   logic       h_act, v_act;

   // Input sampling: S1 is the registered pin, S2 its previous value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_s1  <= 1'b1;
         vs_s1  <= 1'b1;
         hs_s2  <= 1'b1;
         vs_s2  <= 1'b1;
         rgb_s1 <= '0;
         rgb_s2 <= '0;
      end else begin
         hs_s1  <= vgaHs;
         vs_s1  <= vgaVs;
         hs_s2  <= hs_s1;
         vs_s2  <= vs_s1;
         rgb_s1 <= {vgaR, vgaG, vgaB};
         rgb_s2 <= rgb_s1;
      end
   end

   // Vs is only looked at on Hs falling edges, so Vs glitches mid-line are ignored.
   assign hfe = hs_s2 & ~hs_s1;
   assign vfe = hfe & vs_s2 & ~vs_s1;

   // hc/vc hold the length-minus-one of the running line/frame at the edge.
   assign line_viol  = hfe && (hc != H_LAST);
   assign frame_viol = vfe && (vc != V_LAST);
   // Timeouts fire on the cycle the counter steps onto 1023, so a counter
   // parked at saturation does not report again.
   assign h_timeout  = !hfe && (hc == CNT_PRE);
   assign v_timeout  = hfe && !vfe && (vc == CNT_PRE);
   assign viol       = line_viol | frame_viol | h_timeout | v_timeout;

   assign h_act = (hc >= H_START) && (hc < H_END);
   assign v_act = (vc >= V_START) && (vc < V_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc <= '0;
         vc <= '0;
      end else begin
         if (hfe)
            hc <= '0;
         else if (hc != CNT_MAX)
            hc <= hc + 10'd1;
         if (vfe)
            vc <= '0;
         else if (hfe && (vc != CNT_MAX))
            vc <= vc + 10'd1;
      end
   end

   // Lock FSM. seek_bad remembers a violation seen since the SEEK check began;
   // a violation on the VFE cycle itself is folded in directly.
   always_comb begin
      state_next    = state;
      seek_bad_next = seek_bad;
      case (state)
         ST_UNLOCKED: begin
            if (vfe) begin
               state_next    = ST_SEEK;
               seek_bad_next = 1'b0;
            end
         end
         ST_SEEK: begin
            if (vfe) begin
               if (!seek_bad && !viol)
                  state_next = ST_LOCKED;
               seek_bad_next = 1'b0;
            end else if (viol) begin
               seek_bad_next = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (viol)
               state_next = ST_UNLOCKED;
         end
         default: begin
            state_next    = ST_UNLOCKED;
            seek_bad_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_UNLOCKED;
         seek_bad    <= 1'b0;
         sync_err    <= 1'b0;
         err_cnt     <= '0;
         frame_start <= 1'b0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
      end else begin
         state       <= state_next;
         seek_bad    <= seek_bad_next;
         frame_start <= vfe;
         sync_err    <= 1'b0;
         if (viol && (state != ST_UNLOCKED)) begin
            sync_err <= 1'b1;
            if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end
         if ((state == ST_LOCKED) && h_act && v_act) begin
            pix_valid <= 1'b1;
            pix_x     <= hc - H_START;
            pix_y     <= vc - V_START;
            pix_rgb   <= rgb_s2;
         end else begin
            pix_valid <= 1'b0;
         end
      end
   end

   assign locked = (state == ST_LOCKED);

endmodule
